// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared types and constants for the branch sequencing controller
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EVAL     = 2'b01,
        ST_REDIRECT = 2'b10,
        ST_FLUSH    = 2'b11
    } br_state_t;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JAL  = 2'b01,
        BR_JALR = 2'b10,
        BR_RSVD = 2'b11
    } br_kind_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branchalu.sv
// rtl/branchalu.sv - RV32I conditional branch comparator
module branchalu
    import branch_ctrl_pkg::*;
(
    input  logic        en,
    input  logic [2:0]  func3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        taken
);

    // Encodings outside the six defined conditions (010/011) are never taken.
    always_comb begin
        taken = 1'b0;
        if (en) begin
            case (func3)
                F3_BEQ:  taken = (a == b);
                F3_BNE:  taken = (a != b);
                F3_BLT:  taken = ($signed(a) <  $signed(b));
                F3_BGE:  taken = ($signed(a) >= $signed(b));
                F3_BLTU: taken = (a <  b);
                F3_BGEU: taken = (a >= b);
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_seq_ctrl.sv
// rtl/branch_seq_ctrl.sv - multi-cycle branch/jump resolution with held redirect and timed flush
module branch_seq_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_kind,
    input  logic [2:0]       br_func3,
    input  logic [31:0]      br_pc,
    input  logic [31:0]      br_imm,
    input  logic [31:0]      br_rs1,
    input  logic [31:0]      br_rs2,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready,
    output logic             flush,
    output logic             link_valid,
    output logic [31:0]      link_data,
    output logic             misalign,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    br_state_t   state;
    br_kind_t    kind_q;
    logic [2:0]  func3_q;
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [FW-1:0] flush_cnt;
    logic        rst_q;
    logic        alu_taken;
    logic        taken;
    logic        is_jump;
    logic [31:0] target;
    logic        eval_taken;

    branchalu u_alu (
        .en    (kind_q == BR_COND),
        .func3 (func3_q),
        .a     (rs1_q),
        .b     (rs2_q),
        .taken (alu_taken)
    );

    always_comb begin
        taken = 1'b0;
        case (kind_q)
            BR_COND: taken = alu_taken;
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign is_jump    = (kind_q == BR_JAL) || (kind_q == BR_JALR);
    assign target     = (kind_q == BR_JALR) ? ((rs1_q + imm_q) & ~32'd1) : (pc_q + imm_q);
    assign eval_taken = (state == ST_EVAL) && taken;

    // rst_q keeps br_ready low on the cycle right after a reset edge.
    assign br_ready    = (state == ST_IDLE) && !rst_q;
    assign misalign    = eval_taken && target[1];
    assign link_valid  = eval_taken && !target[1] && is_jump;
    assign link_data   = link_valid ? (pc_q + 32'd4) : 32'd0;
    assign redir_valid = (state == ST_REDIRECT);
    assign redir_pc    = redir_valid ? target : 32'd0;
    assign flush       = (state == ST_FLUSH);

    // Operands only load at acceptance, so target stays stable while redirect waits.
    always_ff @(posedge clk) begin
        if (br_ready && br_valid) begin
            kind_q  <= br_kind_t'(br_kind);
            func3_q <= br_func3;
            pc_q    <= br_pc;
            imm_q   <= br_imm;
            rs1_q   <= br_rs1;
            rs2_q   <= br_rs2;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state      <= ST_IDLE;
            flush_cnt  <= '0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (br_ready && br_valid) begin
                        state <= ST_EVAL;
                        if (br_kind == BR_COND && branch_cnt != {CNT_W{1'b1}})
                            branch_cnt <= branch_cnt + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    state <= (taken && !target[1]) ? ST_REDIRECT : ST_IDLE;
                end
                ST_REDIRECT: begin
                    if (redir_ready) begin
                        if (taken_cnt != {CNT_W{1'b1}})
                            taken_cnt <= taken_cnt + CNT_W'(1);
                        if (FLUSH_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FW'(FLUSH_CYCLES);
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt - FW'(1);
                    if (flush_cnt <= FW'(1))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// tb/tb_branch_seq_ctrl.sv - self-checking bench for branch_seq_ctrl with a cycle model
module tb_branch_seq_ctrl;
    import branch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic [1:0]  br_kind = 2'b00;
    logic [2:0]  br_func3 = 3'b000;
    logic [31:0] br_pc = '0, br_imm = '0, br_rs1 = '0, br_rs2 = '0;
    logic        redir_ready = 1'b1;

    logic        a_br_ready, a_redir_valid, a_flush, a_link_valid, a_misalign;
    logic [31:0] a_redir_pc, a_link_data;
    logic [1:0]  a_branch_cnt, a_taken_cnt;
    logic        b_br_ready, b_redir_valid, b_flush, b_link_valid, b_misalign;
    logic [31:0] b_redir_pc, b_link_data;
    logic [15:0] b_branch_cnt, b_taken_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_seq_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(a_br_ready),
        .br_kind(br_kind), .br_func3(br_func3), .br_pc(br_pc), .br_imm(br_imm),
        .br_rs1(br_rs1), .br_rs2(br_rs2), .redir_valid(a_redir_valid),
        .redir_pc(a_redir_pc), .redir_ready(redir_ready), .flush(a_flush),
        .link_valid(a_link_valid), .link_data(a_link_data), .misalign(a_misalign),
        .branch_cnt(a_branch_cnt), .taken_cnt(a_taken_cnt)
    );

    branch_seq_ctrl #(.FLUSH_CYCLES(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(b_br_ready),
        .br_kind(br_kind), .br_func3(br_func3), .br_pc(br_pc), .br_imm(br_imm),
        .br_rs1(br_rs1), .br_rs2(br_rs2), .redir_valid(b_redir_valid),
        .redir_pc(b_redir_pc), .redir_ready(redir_ready), .flush(b_flush),
        .link_valid(b_link_valid), .link_data(b_link_data), .misalign(b_misalign),
        .branch_cnt(b_branch_cnt), .taken_cnt(b_taken_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 resolving, 2 redirect pending, 3 flushing; one entry per DUT.
    int          flc[2]  = '{2, 0};
    int          cmax[2] = '{3, 65535};
    int          m_ph[2], m_left[2], m_bc[2], m_tc[2];
    bit          m_rstq[2], m_tk[2], m_jmp[2];
    logic [31:0] m_tgt[2], m_lnk[2];
    bit          model_on = 0;

    function automatic void resolve(input logic [1:0] k, input logic [2:0] f,
                                    input logic [31:0] pc, input logic [31:0] imm,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output bit tk, output logic [31:0] tgt);
        tk = 0;
        if (k == 2'b00) begin
            case (f)
                3'b000: tk = (a == b);
                3'b001: tk = (a != b);
                3'b100: tk = ($signed(a) < $signed(b));
                3'b101: tk = !($signed(a) < $signed(b));
                3'b110: tk = (a < b);
                3'b111: tk = !(a < b);
                default: tk = 0;
            endcase
        end else if (k != 2'b11) begin
            tk = 1;
        end
        tgt = (k == 2'b10) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit prev_rq;
            prev_rq = m_rstq[i];
            if (rst) begin
                m_ph[i] = 0; m_bc[i] = 0; m_tc[i] = 0; m_rstq[i] = 1;
            end else begin
                m_rstq[i] = 0;
                case (m_ph[i])
                    0: if (br_valid && !prev_rq) begin
                        resolve(br_kind, br_func3, br_pc, br_imm, br_rs1, br_rs2, m_tk[i], m_tgt[i]);
                        m_lnk[i] = br_pc + 32'd4;
                        m_jmp[i] = (br_kind == 2'b01) || (br_kind == 2'b10);
                        if (br_kind == 2'b00 && m_bc[i] < cmax[i]) m_bc[i]++;
                        m_ph[i] = 1;
                    end
                    1: m_ph[i] = (m_tk[i] && !m_tgt[i][1]) ? 2 : 0;
                    2: if (redir_ready) begin
                        if (m_tc[i] < cmax[i]) m_tc[i]++;
                        m_left[i] = flc[i];
                        m_ph[i] = (flc[i] == 0) ? 0 : 3;
                    end
                    default: begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_ph[i] = 0;
                    end
                endcase
            end
        end
        if (rst) model_on = 1;
    endtask

    task automatic cmp(input int i, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic fl, input logic lv, input logic [31:0] ld,
                       input logic mis, input int bc, input int tc);
        bit ev, exp_lv;
        ev     = (m_ph[i] == 1) && m_tk[i];
        exp_lv = ev && !m_tgt[i][1] && m_jmp[i];
        chk($sformatf("d%0d br_ready", i), 32'(rdy), 32'(m_ph[i] == 0 && !m_rstq[i]));
        chk($sformatf("d%0d redir_valid", i), 32'(rv), 32'(m_ph[i] == 2));
        chk($sformatf("d%0d redir_pc", i), rpc, (m_ph[i] == 2) ? m_tgt[i] : 32'd0);
        chk($sformatf("d%0d flush", i), 32'(fl), 32'(m_ph[i] == 3));
        chk($sformatf("d%0d link_valid", i), 32'(lv), 32'(exp_lv));
        chk($sformatf("d%0d link_data", i), ld, exp_lv ? m_lnk[i] : 32'd0);
        chk($sformatf("d%0d misalign", i), 32'(mis), 32'(ev && m_tgt[i][1]));
        chk($sformatf("d%0d branch_cnt", i), 32'(bc), 32'(m_bc[i]));
        chk($sformatf("d%0d taken_cnt", i), 32'(tc), 32'(m_tc[i]));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            cmp(0, a_br_ready, a_redir_valid, a_redir_pc, a_flush, a_link_valid, a_link_data,
                a_misalign, int'(a_branch_cnt), int'(a_taken_cnt));
            cmp(1, b_br_ready, b_redir_valid, b_redir_pc, b_flush, b_link_valid, b_link_data,
                b_misalign, int'(b_branch_cnt), int'(b_taken_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(a_br_ready && b_br_ready) && n < 50) begin step(); n++; end
        chk("wait_idle", 32'(a_br_ready && b_br_ready), 32'd1);
    endtask

    // Returns in the resolve cycle (T+1) of the accepted instruction.
    task automatic issue(input logic [1:0] k, input logic [2:0] f, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        br_valid = 1'b1; br_kind = k; br_func3 = f;
        br_pc = pc; br_imm = imm; br_rs1 = a; br_rs2 = b;
        step();
        br_valid = 1'b0;
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step(); step();
        rst = 1'b0;
        step();
        chk("reset br_ready", 32'(a_br_ready), 32'd1);
        chk("reset taken_cnt", 32'(a_taken_cnt), 32'd0);

        // BEQ taken
        issue(2'b00, F3_BEQ, 32'h100, 32'h20, 32'd5, 32'd5);
        chk("beq link_valid", 32'(a_link_valid), 32'd0);
        step();
        chk("beq redir_valid", 32'(a_redir_valid), 32'd1);
        chk("beq redir_pc", a_redir_pc, 32'h120);
        step();
        chk("beq flush1", 32'(a_flush), 32'd1);
        chk("beq taken_cnt", 32'(a_taken_cnt), 32'd1);
        chk("beq branch_cnt", 32'(a_branch_cnt), 32'd1);
        chk("noflush br_ready", 32'(b_br_ready), 32'd1);
        chk("noflush flush", 32'(b_flush), 32'd0);
        step();
        chk("beq flush2", 32'(a_flush), 32'd1);
        step();
        chk("beq flush end", 32'(a_flush), 32'd0);
        chk("beq ready again", 32'(a_br_ready), 32'd1);

        // BLT signed taken, BLTU not taken
        issue(2'b00, F3_BLT, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("blt redir_pc", a_redir_pc, 32'h340);
        wait_idle();
        issue(2'b00, F3_BLTU, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("bltu br_ready", 32'(a_br_ready), 32'd1);
        chk("bltu redir_valid", 32'(a_redir_valid), 32'd0);

        // JALR aligned and misaligned
        issue(2'b10, 3'b000, 32'h200, 32'h10, 32'h1001, 32'd0);
        chk("jalr link_valid", 32'(a_link_valid), 32'd1);
        chk("jalr link_data", a_link_data, 32'h204);
        step();
        chk("jalr redir_pc", a_redir_pc, 32'h1010);
        wait_idle();
        issue(2'b10, 3'b000, 32'h200, 32'h10, 32'h1003, 32'd0);
        chk("jalr misalign", 32'(a_misalign), 32'd1);
        chk("jalr mis link", 32'(a_link_valid), 32'd0);
        step();
        chk("jalr mis ready", 32'(a_br_ready), 32'd1);
        chk("jalr mis redir", 32'(a_redir_valid), 32'd0);

        // Backpressure with ignored br_valid pulses
        redir_ready = 1'b0;
        issue(2'b01, 3'b000, 32'h400, 32'h80, 32'd0, 32'd0);
        chk("jal link_data", a_link_data, 32'h404);
        step();
        for (int c = 0; c < 5; c++) begin
            br_valid = (c % 2 == 0); br_kind = 2'b00; br_func3 = F3_BEQ;
            br_rs1 = 32'd0; br_rs2 = 32'd0; br_pc = 32'h900;
            chk("bp redir_valid", 32'(a_redir_valid), 32'd1);
            chk("bp redir_pc", a_redir_pc, 32'h480);
            step();
        end
        br_valid = 1'b0;
        chk("bp branch_cnt", 32'(b_branch_cnt), 32'd3);
        redir_ready = 1'b1;
        step();
        chk("bp flush", 32'(a_flush), 32'd1);

        // funct3 010 and reserved kind never taken
        issue(2'b00, 3'b010, 32'h500, 32'h8, 32'd7, 32'd7);
        step();
        chk("f3_010 ready", 32'(a_br_ready), 32'd1);
        chk("f3_010 redir", 32'(a_redir_valid), 32'd0);
        issue(2'b11, 3'b000, 32'h500, 32'h8, 32'd7, 32'd7);
        step();
        chk("rsvd ready", 32'(a_br_ready), 32'd1);

        // Saturation
        for (int c = 0; c < 5; c++) issue(2'b00, F3_BEQ, 32'h600, 32'h4, 32'd1, 32'd1);
        wait_idle();
        chk("sat taken_cnt", 32'(a_taken_cnt), 32'd3);
        chk("sat branch_cnt", 32'(a_branch_cnt), 32'd3);
        chk("wide taken_cnt", 32'(b_taken_cnt), 32'd9);
        chk("wide branch_cnt", 32'(b_branch_cnt), 32'd9);

        // Reset mid-REDIRECT
        redir_ready = 1'b0;
        issue(2'b01, 3'b000, 32'h700, 32'h20, 32'd0, 32'd0);
        step();
        chk("mr redir_valid", 32'(a_redir_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("mr br_ready", 32'(a_br_ready), 32'd0);
        chk("mr redir_valid0", 32'(a_redir_valid), 32'd0);
        chk("mr redir_pc0", a_redir_pc, 32'd0);
        chk("mr taken_cnt", 32'(a_taken_cnt), 32'd0);
        chk("mr branch_cnt", 32'(b_branch_cnt), 32'd0);
        rst = 1'b0;
        redir_ready = 1'b1;
        step();
        chk("mr ready after", 32'(a_br_ready), 32'd1);
        chk("mr dropped", 32'(a_redir_valid), 32'd0);

        // Reset mid-FLUSH
        issue(2'b00, F3_BNE, 32'h800, 32'h10, 32'd1, 32'd2);
        step();
        step();
        chk("mf flush", 32'(a_flush), 32'd1);
        rst = 1'b1;
        step();
        chk("mf flush0", 32'(a_flush), 32'd0);
        chk("mf br_ready", 32'(a_br_ready), 32'd0);
        chk("mf taken_cnt", 32'(a_taken_cnt), 32'd0);
        rst = 1'b0;
        step();
        chk("mf ready after", 32'(a_br_ready), 32'd1);

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
